// File: rtl/dram_cache_pkg.sv
// dram_cache_pkg: shared widths, responder FSM states and request struct for the DRAM-cache read path
package dram_cache_pkg;

    localparam int DATA_W  = 72;
    localparam int TAG_W   = 56;
    localparam int ID_W    = 16;
    localparam int INDEX_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [INDEX_W-1:0] index;
    } req_t;

endpackage

// File: rtl/req_fifo.sv
// req_fifo: synchronous FIFO of request structs with occupancy count; caller never pushes when full or pops when empty
module req_fifo
    import dram_cache_pkg::*;
#(
    parameter type T     = req_t,
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  T                           din_i,
    output T                           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH+1);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [PW-1:0]   r_count;

    assign head_o  = r_mem[r_rd];
    assign count_o = r_count;

    // storage needs no reset: entries are only read once the count says they are valid
    always_ff @(posedge clk) begin
        if (push_i) r_mem[r_wr] <= din_i;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= push_i ? r_wr + AW'(1) : r_wr;
            r_rd    <= pop_i ? r_rd + AW'(1) : r_rd;
            r_count <= r_count + PW'(push_i) - PW'(pop_i);
        end
    end

endmodule

// File: rtl/mem_ctrl_responder.sv
// mem_ctrl_responder: in-order AR/R responder returning {data, tag} from an internal array after a fixed latency
module mem_ctrl_responder
    import dram_cache_pkg::*;
#(
    parameter int ID_WIDTH    = 16,
    parameter int INDEX_WIDTH = 4,
    parameter int DATA_WIDTH  = DATA_W,
    parameter int TAG_WIDTH   = TAG_W,
    parameter int LATENCY     = 4,
    parameter int QDEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_WIDTH-1:0]          arid_i,
    input  logic [INDEX_WIDTH-1:0]       araddr_i,
    input  logic                         arvalid_i,
    output logic                         arready_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic [TAG_WIDTH-1:0]         rtag_o,
    output logic [ID_WIDTH-1:0]          rid_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    input  logic                         fill_en_i,
    input  logic [INDEX_WIDTH-1:0]       fill_index_i,
    input  logic [DATA_WIDTH-1:0]        fill_data_i,
    input  logic [TAG_WIDTH-1:0]         fill_tag_i,
    output logic [$clog2(QDEPTH+1)-1:0]  pending_o
);

    localparam int              PW       = $clog2(QDEPTH+1);
    localparam int              CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(LATENCY-1);
    localparam logic [PW-1:0]   QD       = PW'(QDEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [INDEX_WIDTH-1:0] index;
    } req_w_t;

    resp_state_t            r_state;
    resp_state_t            w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_capture;
    logic                   w_fill_hit;
    logic [PW-1:0]          w_count;
    req_w_t                 w_req;
    req_w_t                 w_head;
    logic [DATA_WIDTH-1:0]  r_data [2**INDEX_WIDTH];
    logic [TAG_WIDTH-1:0]   r_tag  [2**INDEX_WIDTH];
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [TAG_WIDTH-1:0]   r_rtag;
    logic [ID_WIDTH-1:0]    r_rid;

    assign arready_o  = w_count < QD;
    assign w_push     = arvalid_i && arready_o;
    assign w_req      = '{id: arid_i, index: araddr_i};
    assign w_fill_hit = fill_en_i && (fill_index_i == w_head.index);
    assign rvalid_o   = r_state == RESP;
    assign rdata_o    = r_rdata;
    assign rtag_o     = r_rtag;
    assign rid_o      = r_rid;
    assign pending_o  = w_count;

    // the head entry stays queued while in service, so the count covers it until the handshake pops it
    req_fifo #(.T(req_w_t), .DEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_req),
        .head_o  (w_head),
        .count_o (w_count)
    );

    // tag/data array, cleared by reset and written by fills regardless of request traffic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**INDEX_WIDTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else if (fill_en_i) begin
            r_data[fill_index_i] <= fill_data_i;
            r_tag[fill_index_i]  <= fill_tag_i;
        end
    end

    // state and latency counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // IDLE -> WAIT counts down the latency -> RESP holds until rready_i, then serves the next entry
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = (w_count != '0) ? WAIT : IDLE;
                w_cnt_nxt   = CNT_LOAD;
            end
            WAIT: begin
                w_state_nxt = (r_cnt == '0) ? RESP : WAIT;
                w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
                w_capture   = r_cnt == '0;
            end
            RESP: begin
                w_pop       = rready_i;
                w_state_nxt = !rready_i ? RESP : (w_count > PW'(1)) ? WAIT : IDLE;
                w_cnt_nxt   = CNT_LOAD;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // response registers load only on capture, so fills during RESP leave them untouched; a same-edge fill is forwarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_rtag  <= '0;
            r_rid   <= '0;
        end else if (w_capture) begin
            r_rdata <= w_fill_hit ? fill_data_i : r_data[w_head.index];
            r_rtag  <= w_fill_hit ? fill_tag_i : r_tag[w_head.index];
            r_rid   <= w_head.id;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_responder.sv
// tb_mem_ctrl_responder: directed stimulus with a scoreboard queue checked by an independent response monitor
module tb_mem_ctrl_responder;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  arid_i = '0;
    logic [3:0]   araddr_i = '0;
    logic         arvalid_i = 1'b0;
    logic         arready_o;
    logic [71:0]  rdata_o;
    logic [55:0]  rtag_o;
    logic [15:0]  rid_o;
    logic         rvalid_o;
    logic         rready_i = 1'b0;
    logic         fill_en_i = 1'b0;
    logic [3:0]   fill_index_i = '0;
    logic [71:0]  fill_data_i = '0;
    logic [55:0]  fill_tag_i = '0;
    logic [2:0]   pending_o;

    int n_checks = 0;
    int n_errors = 0;
    int edges = 0;

    typedef struct {
        logic [15:0] id;
        logic [71:0] d;
        logic [55:0] t;
    } exp_t;

    exp_t sb[$];

    logic         held = 1'b0;
    logic [71:0]  hd;
    logic [55:0]  ht;
    logic [15:0]  hi;

    mem_ctrl_responder #(.LATENCY(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .arid_i       (arid_i),
        .araddr_i     (araddr_i),
        .arvalid_i    (arvalid_i),
        .arready_o    (arready_o),
        .rdata_o      (rdata_o),
        .rtag_o       (rtag_o),
        .rid_o        (rid_o),
        .rvalid_o     (rvalid_o),
        .rready_i     (rready_i),
        .fill_en_i    (fill_en_i),
        .fill_index_i (fill_index_i),
        .fill_data_i  (fill_data_i),
        .fill_tag_i   (fill_tag_i),
        .pending_o    (pending_o)
    );

    // free-running clock
    always #5 clk = ~clk;

    // edge counter used for latency measurements
    always @(posedge clk) edges++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // response monitor: every handshake pops the oldest expected response
    always @(negedge clk) begin
        if (!rst && rvalid_o && rready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_extra: unexpected response id %0h data %0h", rid_o, rdata_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id", rid_o, e.id);
                chk("resp_data", rdata_o, e.d);
                chk("resp_tag", rtag_o, e.t);
            end
        end
    end

    // a stalled response must keep rvalid_o and its payload unchanged until the handshake
    always @(negedge clk) begin
        if (rst) begin
            held <= 1'b0;
        end else begin
            if (held) begin
                chk("stable_valid", rvalid_o, 1);
                chk("stable_data", rdata_o, hd);
                chk("stable_tag", rtag_o, ht);
                chk("stable_id", rid_o, hi);
            end
            held <= rvalid_o && !rready_i;
            hd   <= rdata_o;
            ht   <= rtag_o;
            hi   <= rid_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [3:0] idx, input logic [71:0] d, input logic [55:0] t);
        fill_en_i    = 1'b1;
        fill_index_i = idx;
        fill_data_i  = d;
        fill_tag_i   = t;
        tick();
        fill_en_i    = 1'b0;
    endtask

    task automatic send(input logic [15:0] id, input logic [3:0] idx, input logic [71:0] d,
                        input logic [55:0] t, output int acc);
        int g = 0;
        arvalid_i = 1'b1;
        arid_i    = id;
        araddr_i  = idx;
        while (!arready_o && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) chk("arready_timeout", arready_o, 1);
        sb.push_back('{id, d, t});
        tick();
        acc       = edges;
        arvalid_i = 1'b0;
    endtask

    task automatic wait_rv();
        int g = 0;
        while (!rvalid_o && g < 100) begin
            tick();
            g++;
        end
        chk("rvalid_seen", rvalid_o, 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((pending_o != 0 || rvalid_o) && g < 200) begin
            tick();
            g++;
        end
        chk("drain_pending", pending_o, 0);
    endtask

    // watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int k;
        int g;
        int times[4];
        for (int i = 0; i < 4; i++) times[i] = 0;

        tick();
        tick();
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_rtag", rtag_o, 0);
        chk("rst_rid", rid_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_arready", arready_o, 1);
        rst = 1'b0;
        tick();
        chk("post_rst_arready", arready_o, 1);

        // latency from IDLE
        rready_i = 1'b1;
        fill(4'd3, 72'hAB, 56'h1234);
        send(16'd7, 4'd3, 72'hAB, 56'h1234, acc);
        wait_rv();
        chk("lat_idle", edges - acc, L + 1);
        chk("lat_data", rdata_o, 72'hAB);
        wait_idle();

        // never-filled index reads back zero
        send(16'h000F, 4'd15, 72'h0, 56'h0, acc);
        wait_idle();

        // four back-to-back requests with rready_i held high
        fill(4'd1, 72'h1111, 56'h11);
        fill(4'd2, 72'h2222, 56'h22);
        fill(4'd4, 72'h4444, 56'h44);
        fill(4'd6, 72'h6666, 56'h66);
        send(16'd1, 4'd1, 72'h1111, 56'h11, acc);
        send(16'd2, 4'd2, 72'h2222, 56'h22, acc);
        send(16'd3, 4'd4, 72'h4444, 56'h44, acc);
        send(16'd4, 4'd6, 72'h6666, 56'h66, acc);
        chk("full_arready", arready_o, 0);
        chk("full_pending", pending_o, 4);
        k = 0;
        g = 0;
        while (k < 4 && g < 100) begin
            if (rvalid_o) begin
                chk("b2b_pending", pending_o, 4 - k);
                times[k] = edges;
                k++;
            end
            tick();
            g++;
        end
        chk("b2b_count", k, 4);
        for (int i = 1; i < 4; i++) chk("b2b_gap", times[i] - times[i-1], L + 1);
        wait_idle();

        // backpressure with a fill to the same index while stalled
        fill(4'd8, 72'hC0FFEE, 56'hBEEF);
        rready_i = 1'b0;
        send(16'h20, 4'd8, 72'hC0FFEE, 56'hBEEF, acc);
        wait_rv();
        for (int i = 0; i < 20; i++) begin
            fill_en_i    = (i == 5);
            fill_index_i = 4'd8;
            fill_data_i  = 72'hDEAD;
            fill_tag_i   = 56'hD0D0;
            tick();
            chk("bp_valid", rvalid_o, 1);
        end
        fill_en_i = 1'b0;
        chk("bp_data", rdata_o, 72'hC0FFEE);
        rready_i = 1'b1;
        tick();
        chk("bp_release", rvalid_o, 0);
        wait_idle();
        send(16'h21, 4'd8, 72'hDEAD, 56'hD0D0, acc);
        wait_idle();

        // fill on the exact capture edge is forwarded
        fill(4'd5, 72'h5, 56'h5);
        send(16'h55, 4'd5, 72'h5A5A, 56'h5B5B, acc);
        for (int i = 0; i < L; i++) tick();
        fill_en_i    = 1'b1;
        fill_index_i = 4'd5;
        fill_data_i  = 72'h5A5A;
        fill_tag_i   = 56'h5B5B;
        tick();
        fill_en_i = 1'b0;
        chk("coll_valid", rvalid_o, 1);
        wait_idle();

        // asynchronous reset with requests pending and a response presented
        rready_i = 1'b0;
        send(16'h31, 4'd3, 72'hAB, 56'h1234, acc);
        send(16'h32, 4'd3, 72'hAB, 56'h1234, acc);
        send(16'h33, 4'd3, 72'hAB, 56'h1234, acc);
        wait_rv();
        chk("pre_rst_pending", pending_o, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rvalid", rvalid_o, 0);
        chk("arst_pending", pending_o, 0);
        chk("arst_arready", arready_o, 1);
        sb.delete();
        tick();
        rst = 1'b0;
        rready_i = 1'b1;
        send(16'h40, 4'd3, 72'h0, 56'h0, acc);
        send(16'h41, 4'd5, 72'h0, 56'h0, acc);
        wait_idle();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
